// File: rtl/unpooling_2x.sv
// 2x2 nearest-neighbour upsampler: every pooled pixel is emitted twice per line and every
// line twice, the second copy of a line being replayed from an internal line buffer.
module unpooling_2x #(
  parameter int unsigned DW   = 16,
  parameter int unsigned IN_W = 16,
  parameter int unsigned IN_H = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          frame_start_in,
  input  logic          line_start_in,
  input  logic          frame_end_in,
  input  logic [DW-1:0] sig_layer,
  output logic [DW-1:0] up_layer,
  output logic          valid,
  output logic          frame_start_out,
  output logic          line_start_out,
  output logic          frame_end_out
);

  localparam int unsigned CW = $clog2(IN_W);
  localparam int unsigned RW = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IN_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IN_H - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_REPLAY = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          ph_q, ph_d;
  logic          last_line_q, last_line_d;
  logic [DW-1:0] hold_q, hold_d;
  logic [DW-1:0] up_layer_q, up_layer_d;
  logic          valid_q, valid_d;
  logic          frame_start_out_q, frame_start_out_d;
  logic          line_start_out_q, line_start_out_d;
  logic          frame_end_out_q, frame_end_out_d;

  logic [DW-1:0] line_buf_q [IN_W];
  logic          buf_we;
  logic [CW-1:0] buf_wa;

  logic accept;
  logic col_last;
  logic fill_done;
  logic replay_done;
  logic frame_done;
  logic unused_line_start;

  // Line-start marker is informational only; framing is derived from the counters.
  assign unused_line_start = line_start_in;

  assign in_ready    = (state_q == S_IDLE) || ((state_q == S_FILL) && !ph_q);
  // In IDLE only a frame-start pixel is taken into the pipeline; others are swallowed.
  assign accept      = in_valid && in_ready && ((state_q != S_IDLE) || frame_start_in);
  assign col_last    = (col_q == COL_LAST);
  assign fill_done   = (state_q == S_FILL) && ph_q && col_last;
  assign replay_done = (state_q == S_REPLAY) && ph_q && col_last;
  assign frame_done  = (row_q == ROW_LAST) || last_line_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q             <= '0;
      row_q             <= '0;
      ph_q              <= 1'b0;
      last_line_q       <= 1'b0;
      hold_q            <= '0;
      up_layer_q        <= '0;
      valid_q           <= 1'b0;
      frame_start_out_q <= 1'b0;
      line_start_out_q  <= 1'b0;
      frame_end_out_q   <= 1'b0;
    end else begin
      col_q             <= col_d;
      row_q             <= row_d;
      ph_q              <= ph_d;
      last_line_q       <= last_line_d;
      hold_q            <= hold_d;
      up_layer_q        <= up_layer_d;
      valid_q           <= valid_d;
      frame_start_out_q <= frame_start_out_d;
      line_start_out_q  <= line_start_out_d;
      frame_end_out_q   <= frame_end_out_d;
    end
  end

  // Line buffer holds the current input line for the vertical replay; no reset needed.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      line_buf_q[buf_wa] <= sig_layer;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_FILL;
      S_FILL:   if (fill_done) state_d = S_REPLAY;
      S_REPLAY: if (replay_done) state_d = frame_done ? S_IDLE : S_FILL;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    col_d             = col_q;
    row_d             = row_q;
    ph_d              = ph_q;
    last_line_d       = last_line_q;
    hold_d            = hold_q;
    up_layer_d        = up_layer_q;
    valid_d           = 1'b0;
    frame_start_out_d = 1'b0;
    line_start_out_d  = 1'b0;
    frame_end_out_d   = 1'b0;
    buf_we            = 1'b0;
    buf_wa            = col_q;
    case (state_q)
      S_IDLE, S_FILL: begin
        if (accept) begin
          buf_we     = 1'b1;
          hold_d     = sig_layer;
          up_layer_d = sig_layer;
          valid_d    = 1'b1;
          ph_d       = 1'b1;
          // A frame start always restarts at col 0 / row 0, abandoning any partial line.
          if (frame_start_in) begin
            buf_wa            = '0;
            col_d             = '0;
            row_d             = '0;
            last_line_d       = frame_end_in;
            frame_start_out_d = 1'b1;
            line_start_out_d  = 1'b1;
          end else begin
            last_line_d      = last_line_q | frame_end_in;
            line_start_out_d = (col_q == '0);
          end
        end else if ((state_q == S_FILL) && ph_q) begin
          up_layer_d = hold_q;
          valid_d    = 1'b1;
          ph_d       = 1'b0;
          col_d      = col_last ? '0 : col_q + CW'(1);
        end
      end
      S_REPLAY: begin
        valid_d          = 1'b1;
        up_layer_d       = line_buf_q[col_q];
        line_start_out_d = (col_q == '0) && !ph_q;
        ph_d             = ~ph_q;
        if (ph_q) begin
          col_d = col_last ? '0 : col_q + CW'(1);
        end
        if (replay_done) begin
          if (frame_done) begin
            row_d           = '0;
            last_line_d     = 1'b0;
            frame_end_out_d = 1'b1;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: begin
        ph_d = 1'b0;
      end
    endcase
  end

  assign up_layer        = up_layer_q;
  assign valid           = valid_q;
  assign frame_start_out = frame_start_out_q;
  assign line_start_out  = line_start_out_q;
  assign frame_end_out   = frame_end_out_q;

endmodule

// File: tb/tb_unpooling_2x.sv
// Bench for unpooling_2x: random pixel streams checked against a frame-level reference
// model that expands each accepted pixel/line into its expected upsampled output.
module tb_unpooling_2x;

  localparam int unsigned DW   = 16;
  localparam int unsigned IN_W = 4;
  localparam int unsigned IN_H = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          frame_start_in;
  logic          line_start_in;
  logic          frame_end_in;
  logic [DW-1:0] sig_layer;
  logic [DW-1:0] up_layer;
  logic          valid;
  logic          frame_start_out;
  logic          line_start_out;
  logic          frame_end_out;

  typedef struct {
    logic [DW-1:0] d;
    logic          fs;
    logic          ls;
    logic          fe;
    int            cyc;
  } pix_t;

  pix_t got_q[$];
  pix_t exp_q[$];
  int   cyc = 0;
  int   stray = 0;
  int   checks = 0;
  int   fails = 0;
  bit   rdy_hist [8192];

  logic [DW-1:0] m_line [IN_W];
  int            m_col, m_row;
  bit            m_act, m_last;

  unpooling_2x #(.DW(DW), .IN_W(IN_W), .IN_H(IN_H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .frame_start_in(frame_start_in), .line_start_in(line_start_in),
    .frame_end_in(frame_end_in), .sig_layer(sig_layer), .up_layer(up_layer),
    .valid(valid), .frame_start_out(frame_start_out), .line_start_out(line_start_out),
    .frame_end_out(frame_end_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Output recorder: logs every valid pixel with its cycle, counts flags seen without valid.
  always @(negedge clk) begin
    if (cyc < 8192) rdy_hist[cyc] = in_ready;
    if (!rst) begin
      if (valid)
        got_q.push_back('{d: up_layer, fs: frame_start_out, ls: line_start_out,
                          fe: frame_end_out, cyc: cyc});
      else if (frame_start_out || line_start_out || frame_end_out)
        stray++;
    end
  end

  function automatic void model_reset();
    m_act = 0; m_col = 0; m_row = 0; m_last = 0;
  endfunction

  // Reference: each pixel appears twice; a completed line is then repeated pixel-doubled.
  function automatic void model_accept(input logic [DW-1:0] d, input bit fs, input bit fe);
    bit end_f;
    if (fs) begin m_act = 1; m_col = 0; m_row = 0; m_last = 0; end
    if (!m_act) return;
    m_last = m_last | fe;
    m_line[m_col] = d;
    exp_q.push_back('{d: d, fs: fs, ls: (m_col == 0), fe: 1'b0, cyc: 0});
    exp_q.push_back('{d: d, fs: 1'b0, ls: 1'b0, fe: 1'b0, cyc: 0});
    m_col++;
    if (m_col == IN_W) begin
      end_f = (m_row == IN_H - 1) || m_last;
      for (int i = 0; i < 2 * IN_W; i++)
        exp_q.push_back('{d: m_line[i/2], fs: 1'b0, ls: (i == 0),
                          fe: end_f && (i == 2 * IN_W - 1), cyc: 0});
      m_col = 0;
      if (end_f) begin m_act = 0; m_row = 0; m_last = 0; end
      else m_row++;
    end
  endfunction

  // Called at a negedge; 'gap' counts ready cycles left idle before presenting the pixel.
  task automatic send(input logic [DW-1:0] d, input bit fs, input bit fe, input int gap,
                      output int t);
    int n;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      n = 0;
      while (!in_ready && n < 200) begin @(negedge clk); n++; end
      @(negedge clk);
    end
    sig_layer = d; frame_start_in = fs; frame_end_in = fe;
    line_start_in = fs || (m_col == 0);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!in_ready) begin
      fails++;
      $display("FAIL send_ready_timeout pixel=%h in_ready=%b required=1", d, in_ready);
      t = -1;
    end else begin
      t = cyc;
      model_accept(d, fs, fe);
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0; frame_start_in = 1'b0; frame_end_in = 1'b0;
    while (got_q.size() < exp_q.size() && n < 400) begin @(negedge clk); n++; end
    repeat (8) @(negedge clk);
  endtask

  task automatic start_test();
    got_q.delete(); exp_q.delete(); stray = 0; model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; frame_start_in = 1'b0; line_start_in = 1'b0;
    frame_end_in = 1'b0; sig_layer = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({valid, frame_start_out, line_start_out, frame_end_out} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags got=%b%b%b%b required=0000", valid, frame_start_out,
               line_start_out, frame_end_out);
    end
    checks++;
    if (up_layer !== '0) begin fails++; $display("FAIL reset_data got=%h required=0", up_layer); end
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b required=1", in_ready); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL post_reset_idle valid=%b in_ready=%b required valid=0 in_ready=1", valid, in_ready);
    end
  endtask

  task automatic test_basic();
    logic [DW-1:0] px [IN_W*IN_H];
    int t, t0;
    bit exp_r;
    start_test();
    t0 = -1;
    for (int i = 0; i < IN_W * IN_H; i++) px[i] = DW'($urandom);
    for (int i = 0; i < IN_W * IN_H; i++) begin
      send(px[i], (i == 0), 1'b0, 0, t);
      if (i == 0) t0 = t;
    end
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL basic_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if ({got_q[i].d, got_q[i].fs, got_q[i].ls, got_q[i].fe} !==
          {exp_q[i].d, exp_q[i].fs, exp_q[i].ls, exp_q[i].fe}) begin
        fails++;
        $display("FAIL basic_pix[%0d] got d=%h fs/ls/fe=%b%b%b required d=%h fs/ls/fe=%b%b%b", i,
                 got_q[i].d, got_q[i].fs, got_q[i].ls, got_q[i].fe,
                 exp_q[i].d, exp_q[i].fs, exp_q[i].ls, exp_q[i].fe);
      end
    end
    for (int i = 1; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].cyc != got_q[0].cyc + i) begin
        fails++; $display("FAIL basic_contig[%0d] got cyc=%0d required=%0d", i, got_q[i].cyc, got_q[0].cyc + i);
      end
    end
    if (t0 >= 0 && got_q.size() > 0) begin
      checks++;
      if (got_q[0].cyc != t0 + 1) begin
        fails++; $display("FAIL basic_latency got cyc=%0d required=%0d", got_q[0].cyc, t0 + 1);
      end
      for (int i = 0; i < 4 * IN_W * IN_H; i++) begin
        exp_r = ((i % (4 * IN_W)) < 2 * IN_W) && (i % 2 == 0);
        checks++;
        if (rdy_hist[t0 + i] !== exp_r) begin
          fails++; $display("FAIL basic_ready[%0d] got=%b required=%b", i, rdy_hist[t0 + i], exp_r);
        end
      end
    end
    checks++;
    if (stray != 0) begin fails++; $display("FAIL basic_stray_flags got=%0d required=0", stray); end
  endtask

  task automatic test_bubble();
    logic [DW-1:0] px [IN_W*IN_H];
    int t, tc;
    start_test();
    tc = -1;
    for (int i = 0; i < IN_W * IN_H; i++) px[i] = DW'($urandom);
    for (int i = 0; i < IN_W * IN_H; i++) begin
      send(px[i], (i == 0), 1'b0, (i == 2) ? 3 : 0, t);
      if (i == 2) tc = t;
    end
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL bubble_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if ({got_q[i].d, got_q[i].fs, got_q[i].ls, got_q[i].fe} !==
          {exp_q[i].d, exp_q[i].fs, exp_q[i].ls, exp_q[i].fe}) begin
        fails++;
        $display("FAIL bubble_pix[%0d] got d=%h fs/ls/fe=%b%b%b required d=%h fs/ls/fe=%b%b%b", i,
                 got_q[i].d, got_q[i].fs, got_q[i].ls, got_q[i].fe,
                 exp_q[i].d, exp_q[i].fs, exp_q[i].ls, exp_q[i].fe);
      end
    end
    if (got_q.size() >= 4 * IN_W) begin
      checks++;
      if (got_q[4].cyc - got_q[3].cyc != 4) begin
        fails++; $display("FAIL bubble_gap got=%0d idle cycles required=3", got_q[4].cyc - got_q[3].cyc - 1);
      end
      checks++;
      if (got_q[4].cyc != tc + 1) begin
        fails++; $display("FAIL bubble_latency got cyc=%0d required=%0d", got_q[4].cyc, tc + 1);
      end
      for (int i = 2 * IN_W; i < 4 * IN_W; i++) begin
        checks++;
        if (got_q[i].cyc != got_q[2 * IN_W - 1].cyc + (i - 2 * IN_W + 1)) begin
          fails++; $display("FAIL bubble_replay_contig[%0d] got cyc=%0d required=%0d", i,
                            got_q[i].cyc, got_q[2 * IN_W - 1].cyc + (i - 2 * IN_W + 1));
        end
      end
    end
  endtask

  task automatic test_idle_drop();
    int t;
    start_test();
    send(16'h0011, 1'b0, 1'b0, 0, t);
    send(16'h0022, 1'b0, 1'b0, 0, t);
    drain();
    checks++;
    if (got_q.size() != 0) begin fails++; $display("FAIL idle_drop_output got=%0d pixels required=0", got_q.size()); end
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL idle_drop_ready got=%b required=1", in_ready); end
    start_test();
    for (int i = 0; i < IN_W * IN_H; i++) send(DW'($urandom), (i == 0), 1'b0, 0, t);
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL idle_frame_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if ({got_q[i].d, got_q[i].fs, got_q[i].ls, got_q[i].fe} !==
          {exp_q[i].d, exp_q[i].fs, exp_q[i].ls, exp_q[i].fe}) begin
        fails++;
        $display("FAIL idle_frame_pix[%0d] got d=%h fs/ls/fe=%b%b%b required d=%h fs/ls/fe=%b%b%b", i,
                 got_q[i].d, got_q[i].fs, got_q[i].ls, got_q[i].fe,
                 exp_q[i].d, exp_q[i].fs, exp_q[i].ls, exp_q[i].fe);
      end
    end
  endtask

  task automatic test_frame_end();
    int t;
    start_test();
    for (int i = 0; i < IN_W; i++) send(DW'($urandom), (i == 0), (i == IN_W - 1), 0, t);
    // Once back in IDLE, a pixel without frame start must be swallowed.
    send(16'h0033, 1'b0, 1'b0, 0, t);
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL frame_end_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if ({got_q[i].d, got_q[i].fs, got_q[i].ls, got_q[i].fe} !==
          {exp_q[i].d, exp_q[i].fs, exp_q[i].ls, exp_q[i].fe}) begin
        fails++;
        $display("FAIL frame_end_pix[%0d] got d=%h fs/ls/fe=%b%b%b required d=%h fs/ls/fe=%b%b%b", i,
                 got_q[i].d, got_q[i].fs, got_q[i].ls, got_q[i].fe,
                 exp_q[i].d, exp_q[i].fs, exp_q[i].ls, exp_q[i].fe);
      end
    end
  endtask

  task automatic test_resync();
    int t, nfs;
    start_test();
    for (int i = 0; i < 2 + IN_W * IN_H; i++)
      send(DW'($urandom), (i == 0) || (i == 2), 1'b0, 0, t);
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL resync_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if ({got_q[i].d, got_q[i].fs, got_q[i].ls, got_q[i].fe} !==
          {exp_q[i].d, exp_q[i].fs, exp_q[i].ls, exp_q[i].fe}) begin
        fails++;
        $display("FAIL resync_pix[%0d] got d=%h fs/ls/fe=%b%b%b required d=%h fs/ls/fe=%b%b%b", i,
                 got_q[i].d, got_q[i].fs, got_q[i].ls, got_q[i].fe,
                 exp_q[i].d, exp_q[i].fs, exp_q[i].ls, exp_q[i].fe);
      end
    end
    nfs = 0;
    foreach (got_q[i]) if (got_q[i].fs) nfs++;
    checks++;
    if (nfs != 2) begin fails++; $display("FAIL resync_frame_starts got=%0d required=2", nfs); end
  endtask

  task automatic test_reset_mid();
    int t;
    start_test();
    for (int i = 0; i < IN_W; i++) send(DW'($urandom), (i == 0), 1'b0, 0, t);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({valid, frame_start_out, line_start_out, frame_end_out} !== 4'b0000 || up_layer !== '0) begin
      fails++;
      $display("FAIL reset_mid_outputs got valid/fs/ls/fe=%b%b%b%b data=%h required 0000 data=0",
               valid, frame_start_out, line_start_out, frame_end_out, up_layer);
    end
    @(negedge clk);
    rst = 1'b0;
    start_test();
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_mid_ready got=%b required=1", in_ready); end
    for (int i = 0; i < IN_W * IN_H; i++) send(DW'($urandom), (i == 0), 1'b0, 0, t);
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL reset_mid_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if ({got_q[i].d, got_q[i].fs, got_q[i].ls, got_q[i].fe} !==
          {exp_q[i].d, exp_q[i].fs, exp_q[i].ls, exp_q[i].fe}) begin
        fails++;
        $display("FAIL reset_mid_pix[%0d] got d=%h fs/ls/fe=%b%b%b required d=%h fs/ls/fe=%b%b%b", i,
                 got_q[i].d, got_q[i].fs, got_q[i].ls, got_q[i].fe,
                 exp_q[i].d, exp_q[i].fs, exp_q[i].ls, exp_q[i].fe);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t;
    start_test();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < IN_W * IN_H; i++)
        send(DW'($urandom), (i == 0), 1'b0, int'($urandom_range(0, 2)), t);
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL b2b_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if ({got_q[i].d, got_q[i].fs, got_q[i].ls, got_q[i].fe} !==
          {exp_q[i].d, exp_q[i].fs, exp_q[i].ls, exp_q[i].fe}) begin
        fails++;
        $display("FAIL b2b_pix[%0d] got d=%h fs/ls/fe=%b%b%b required d=%h fs/ls/fe=%b%b%b", i,
                 got_q[i].d, got_q[i].fs, got_q[i].ls, got_q[i].fe,
                 exp_q[i].d, exp_q[i].fs, exp_q[i].ls, exp_q[i].fe);
      end
    end
    checks++;
    if (stray != 0) begin fails++; $display("FAIL b2b_stray_flags got=%0d required=0", stray); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubble();
    test_idle_drop();
    test_frame_end();
    test_resync();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout cyc=%0d required completion", cyc);
    $fatal(1);
  end

endmodule
